glitc_i2c_update_sequencer: RTL and testbench

//  Hardware sequencer for the external-settings I2C bus: replaces the firmware-driven update loop.

---
 rtl/glitc_i2c_update_sequencer_pkg.sv | 36 +++
 rtl/glitc_rr_arbiter.sv | 36 +++
 rtl/glitc_i2c_update_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_glitc_i2c_update_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitc_i2c_update_sequencer_pkg.sv
// Shared constants, state encoding and error-code helper for the I2C update sequencer.
// Register map and bit masks follow the OpenCores i2c_master_top WISHBONE interface.
package glitc_i2c_update_sequencer_pkg;

    localparam logic [2:0] RegPrerLo = 3'd0;
    localparam logic [2:0] RegPrerHi = 3'd1;
    localparam logic [2:0] RegCtr    = 3'd2;
    localparam logic [2:0] RegTxr    = 3'd3;
    localparam logic [2:0] RegCr     = 3'd4;
    localparam logic [2:0] RegSr     = 3'd4;

    localparam logic [7:0] CrSta = 8'h80;
    localparam logic [7:0] CrSto = 8'h40;
    localparam logic [7:0] CrWr  = 8'h10;
    localparam logic [7:0] CtrEn = 8'h80;

    localparam int unsigned SrRxAck = 7;
    localparam int unsigned SrBusy  = 6;
    localparam int unsigned SrTip   = 1;

    localparam logic [1:0] ErrNack    = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;

    localparam int unsigned NumChan = 14;

    typedef enum logic [3:0] {
        StInitCtr0, StInitPlo, StInitPhi, StInitEn, StIdle, StSelect, StTxLoad,
        StTxCmd, StPoll, StCheck, StStop, StStopPoll, StDone, StToStop
    } state_e;

    function automatic logic [7:0] err_code(input logic [1:0] kind, input logic is_att,
                                            input logic [1:0] byte_idx, input logic [2:0] ch);
        return {kind, is_att, byte_idx, ch};
    endfunction

endpackage

// File: rtl/glitc_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping at N.
module glitc_rr_arbiter #(
    parameter int unsigned N = 14,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] grant_o,
    output logic         valid_o
);

    localparam int unsigned SW = W + 1;

    logic [SW-1:0] sum;
    logic [W-1:0]  idx;

    // Walk offsets from far to near so the nearest request wins.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_i} + SW'(i);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[W-1:0];
            if (req_i[idx]) begin
                valid_o = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/glitc_i2c_update_sequencer.sv
// Hardware I2C update sequencer: arbitrates DAC/attenuator pending flags and writes them via WB.
// Optional poll timeout and core re-init enabled by defining GLITC_I2C_TIMEOUT_EN.
module glitc_i2c_update_sequencer #(
    parameter logic [15:0] PRESCALE      = 16'd49,
    parameter logic [6:0]  DAC_ADDR      = 7'h60,
    parameter logic [6:0]  ATT_ADDR_BASE = 7'h20,
    parameter logic [19:0] TIMEOUT_CYC   = 20'd500000
) (
    input  logic        user_clk_i,
    input  logic        user_rst_i,
    input  logic [7:0]  dac_pending_i,
    input  logic [95:0] dac_value_i,
    input  logic [7:0]  dac_eeprom_i,
    input  logic [5:0]  atten_pending_i,
    input  logic [35:0] atten_value_i,
    input  logic        pause_i,
    input  logic        init_req_i,
    output logic [7:0]  clr_dac_o,
    output logic [5:0]  clr_atten_o,
    output logic        initialized_o,
    output logic        busy_o,
    output logic        err_valid_o,
    output logic [7:0]  err_code_o,
    input  logic        err_ack_i,
    output logic [2:0]  wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    import glitc_i2c_update_sequencer_pkg::*;

    state_e          state_q, state_d;
    logic [3:0]      ptr_q, ptr_d;
    logic            is_att_q, is_att_d;
    logic [2:0]      ch_q, ch_d;
    logic [3:0][7:0] byte_q, byte_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      idx_q, idx_d;
    logic            rxack_q, rxack_d;
    logic            init_req_q, init_req_d;
    logic            initialized_q, initialized_d;
    logic            busy_q;
    logic            err_valid_q, err_valid_d;
    logic [7:0]      err_code_q, err_code_d;
    logic            wb_cyc_q, wb_cyc_d;
    logic            wb_we_q, wb_we_d;
    logic [2:0]      wb_adr_q, wb_adr_d;
    logic [7:0]      wb_dat_q, wb_dat_d;

    logic       acc_req, acc_we;
    logic [2:0] acc_adr;
    logic [7:0] acc_dat;
    logic       wb_done, err_set, clr_fire, tmo_hit;
    logic [7:0] err_new;
    logic [3:0] grant_idx, served_idx;
    logic       grant_valid;
    logic [11:0] dac_val;
    logic [5:0]  att_val;

    glitc_rr_arbiter #(
        .N (NumChan),
        .W (4)
    ) u_arb (
        .req_i   ({atten_pending_i, dac_pending_i}),
        .ptr_i   (ptr_q),
        .grant_o (grant_idx),
        .valid_o (grant_valid)
    );

    assign wb_done    = wb_cyc_q & wb_ack_i;
    assign served_idx = {is_att_q, ch_q};
    assign dac_val    = dac_value_i[12*grant_idx[2:0] +: 12];
    assign att_val    = atten_value_i[6*grant_idx[2:0] +: 6];

`ifdef GLITC_I2C_TIMEOUT_EN
    logic [19:0] tmo_cnt_q;
    logic        in_poll;

    assign in_poll = (state_q == StPoll) || (state_q == StStopPoll);
    assign tmo_hit = (tmo_cnt_q >= TIMEOUT_CYC);

    always_ff @(posedge user_clk_i) begin
        if (user_rst_i || !in_poll) begin
            tmo_cnt_q <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 20'd1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign tmo_hit    = 1'b0;
`endif

    logic unused_rd;
    assign unused_rd = ^wb_dat_i;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        is_att_d      = is_att_q;
        ch_d          = ch_q;
        byte_d        = byte_q;
        last_d        = last_q;
        idx_d         = idx_q;
        rxack_d       = rxack_q;
        init_req_d    = init_req_q | init_req_i;
        initialized_d = initialized_q;
        acc_req       = 1'b0;
        acc_we        = 1'b1;
        acc_adr       = RegCtr;
        acc_dat       = 8'h00;
        err_set       = 1'b0;
        err_new       = 8'h00;
        clr_fire      = 1'b0;

        unique case (state_q)
            StInitCtr0: begin
                acc_req = 1'b1;
                if (wb_done) state_d = StInitPlo;
            end
            StInitPlo: begin
                acc_req = 1'b1;
                acc_adr = RegPrerLo;
                acc_dat = PRESCALE[7:0];
                if (wb_done) state_d = StInitPhi;
            end
            StInitPhi: begin
                acc_req = 1'b1;
                acc_adr = RegPrerHi;
                acc_dat = PRESCALE[15:8];
                if (wb_done) state_d = StInitEn;
            end
            StInitEn: begin
                acc_req = 1'b1;
                acc_dat = CtrEn;
                if (wb_done) begin
                    state_d       = StIdle;
                    initialized_d = 1'b1;
                end
            end
            StIdle: begin
                if (init_req_q || init_req_i) begin
                    state_d       = StInitCtr0;
                    initialized_d = 1'b0;
                    init_req_d    = 1'b0;
                end else if (!pause_i && grant_valid) begin
                    state_d = StSelect;
                end
            end
            StSelect: begin
                // Frame contents are frozen here; later pending/value changes do not affect it.
                if (!grant_valid) begin
                    state_d = StIdle;
                end else begin
                    is_att_d = grant_idx[3];
                    ch_d     = grant_idx[2:0];
                    idx_d    = 2'd0;
                    state_d  = StTxLoad;
                    if (!grant_idx[3]) begin
                        byte_d[0] = {DAC_ADDR, 1'b0};
                        byte_d[1] = {3'b010, dac_eeprom_i[grant_idx[2:0]], 1'b0, grant_idx[2:0]};
                        byte_d[2] = dac_val[11:4];
                        byte_d[3] = {dac_val[3:0], 4'h0};
                        last_d    = 2'd3;
                    end else begin
                        byte_d[0] = {ATT_ADDR_BASE + {4'b0000, grant_idx[2:0]}, 1'b0};
                        byte_d[1] = {2'b00, att_val};
                        byte_d[2] = 8'h00;
                        byte_d[3] = 8'h00;
                        last_d    = 2'd1;
                    end
                end
            end
            StTxLoad: begin
                acc_req = 1'b1;
                acc_adr = RegTxr;
                acc_dat = byte_q[idx_q];
                if (wb_done) state_d = StTxCmd;
            end
            StTxCmd: begin
                acc_req = 1'b1;
                acc_adr = RegCr;
                acc_dat = (idx_q == 2'd0) ? (CrSta | CrWr) : CrWr;
                if (wb_done) state_d = StPoll;
            end
            StPoll: begin
                acc_req = 1'b1;
                acc_we  = 1'b0;
                acc_adr = RegSr;
                if (wb_done) begin
                    if (!wb_dat_i[SrTip]) begin
                        rxack_d = wb_dat_i[SrRxAck];
                        state_d = StCheck;
                    end else if (tmo_hit) begin
                        err_set = 1'b1;
                        err_new = err_code(ErrTimeout, is_att_q, idx_q, ch_q);
                        state_d = StToStop;
                    end
                end
            end
            StCheck: begin
                if (rxack_q) begin
                    err_set = 1'b1;
                    err_new = err_code(ErrNack, is_att_q, idx_q, ch_q);
                    state_d = StStop;
                end else if (idx_q == last_q) begin
                    state_d = StStop;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StTxLoad;
                end
            end
            StStop: begin
                acc_req = 1'b1;
                acc_adr = RegCr;
                acc_dat = CrSto;
                if (wb_done) state_d = StStopPoll;
            end
            StStopPoll: begin
                acc_req = 1'b1;
                acc_we  = 1'b0;
                acc_adr = RegSr;
                if (wb_done) begin
                    if (!wb_dat_i[SrBusy]) begin
                        state_d = StDone;
                    end else if (tmo_hit) begin
                        err_set = 1'b1;
                        err_new = err_code(ErrTimeout, is_att_q, idx_q, ch_q);
                        state_d = StToStop;
                    end
                end
            end
            StDone: begin
                clr_fire = 1'b1;
                ptr_d    = (served_idx == 4'd13) ? 4'd0 : served_idx + 4'd1;
                state_d  = StIdle;
            end
            StToStop: begin
                // Stuck core: release the bus, drop the channel and reconfigure the core.
                acc_req = 1'b1;
                acc_adr = RegCr;
                acc_dat = CrSto;
                if (wb_done) begin
                    clr_fire      = 1'b1;
                    ptr_d         = (served_idx == 4'd13) ? 4'd0 : served_idx + 4'd1;
                    initialized_d = 1'b0;
                    state_d       = StInitCtr0;
                end
            end
            default: state_d = StInitCtr0;
        endcase
    end

    // One WB access at a time; cyc drops for at least one cycle after every ack.
    always_comb begin
        wb_cyc_d = wb_cyc_q;
        wb_we_d  = wb_we_q;
        wb_adr_d = wb_adr_q;
        wb_dat_d = wb_dat_q;
        if (wb_cyc_q) begin
            if (wb_ack_i) begin
                wb_cyc_d = 1'b0;
                wb_we_d  = 1'b0;
            end
        end else if (acc_req) begin
            wb_cyc_d = 1'b1;
            wb_we_d  = acc_we;
            wb_adr_d = acc_adr;
            wb_dat_d = acc_dat;
        end
    end

    always_comb begin
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        if (err_ack_i) begin
            err_valid_d = 1'b0;
            err_code_d  = 8'h00;
        end
        if (err_set && (!err_valid_q || err_ack_i)) begin
            err_valid_d = 1'b1;
            err_code_d  = err_new;
        end
    end

    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            state_q       <= StInitCtr0;
            ptr_q         <= '0;
            is_att_q      <= 1'b0;
            ch_q          <= '0;
            byte_q        <= '0;
            last_q        <= '0;
            idx_q         <= '0;
            rxack_q       <= 1'b0;
            init_req_q    <= 1'b0;
            initialized_q <= 1'b0;
            busy_q        <= 1'b0;
            err_valid_q   <= 1'b0;
            err_code_q    <= '0;
            wb_cyc_q      <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_adr_q      <= '0;
            wb_dat_q      <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            is_att_q      <= is_att_d;
            ch_q          <= ch_d;
            byte_q        <= byte_d;
            last_q        <= last_d;
            idx_q         <= idx_d;
            rxack_q       <= rxack_d;
            init_req_q    <= init_req_d;
            initialized_q <= initialized_d;
            busy_q        <= (state_d != StIdle);
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
            wb_cyc_q      <= wb_cyc_d;
            wb_we_q       <= wb_we_d;
            wb_adr_q      <= wb_adr_d;
            wb_dat_q      <= wb_dat_d;
        end
    end

    assign clr_dac_o     = (clr_fire && !is_att_q) ? (8'b1 << ch_q) : 8'h00;
    assign clr_atten_o   = (clr_fire && is_att_q) ? (6'b1 << ch_q) : 6'h00;
    assign initialized_o = initialized_q;
    assign busy_o        = busy_q;
    assign err_valid_o   = err_valid_q;
    assign err_code_o    = err_code_q;
    assign wb_cyc_o      = wb_cyc_q;
    assign wb_stb_o      = wb_cyc_q;
    assign wb_we_o       = wb_we_q;
    assign wb_adr_o      = wb_adr_q;
    assign wb_dat_o      = wb_dat_q;

endmodule

// File: tb/tb_glitc_i2c_update_sequencer.sv
// Directed bench: I2C core model on the WB port, upstream pending model, write-log checking.
module tb_glitc_i2c_update_sequencer;

    logic        user_clk_i = 1'b0;
    logic        user_rst_i;
    logic [7:0]  dac_pending_i;
    logic [95:0] dac_value_i;
    logic [7:0]  dac_eeprom_i;
    logic [5:0]  atten_pending_i;
    logic [35:0] atten_value_i;
    logic        pause_i, init_req_i, err_ack_i;
    logic [7:0]  clr_dac_o;
    logic [5:0]  clr_atten_o;
    logic        initialized_o, busy_o, err_valid_o;
    logic [7:0]  err_code_o;
    logic [2:0]  wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i = 8'h00;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i = 1'b0;

    always #5 user_clk_i = ~user_clk_i;

    glitc_i2c_update_sequencer #(
        .TIMEOUT_CYC (20'd200)
    ) dut (
        .user_clk_i      (user_clk_i),
        .user_rst_i      (user_rst_i),
        .dac_pending_i   (dac_pending_i),
        .dac_value_i     (dac_value_i),
        .dac_eeprom_i    (dac_eeprom_i),
        .atten_pending_i (atten_pending_i),
        .atten_value_i   (atten_value_i),
        .pause_i         (pause_i),
        .init_req_i      (init_req_i),
        .clr_dac_o       (clr_dac_o),
        .clr_atten_o     (clr_atten_o),
        .initialized_o   (initialized_o),
        .busy_o          (busy_o),
        .err_valid_o     (err_valid_o),
        .err_code_o      (err_code_o),
        .err_ack_i       (err_ack_i),
        .wb_adr_o        (wb_adr_o),
        .wb_dat_o        (wb_dat_o),
        .wb_dat_i        (wb_dat_i),
        .wb_we_o         (wb_we_o),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_ack_i        (wb_ack_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // I2C core model: acks one cycle after strobe, logs writes, TIP/BUSY clear after two SR reads.
    logic [15:0] wr_log[$];
    int          tip_cnt = 0;
    int          stop_cnt = 0;
    logic        rxack_m = 1'b0;
    logic [7:0]  last_txr = 8'h00;
    logic        nack_en = 1'b0;
    logic        tip_stuck = 1'b0;

    always @(negedge user_clk_i) begin
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            wb_ack_i = 1'b1;
            if (wb_we_o) begin
                wr_log.push_back({5'b0, wb_adr_o, wb_dat_o});
                if (wb_adr_o == 3'd3) last_txr = wb_dat_o;
                if (wb_adr_o == 3'd4) begin
                    if (wb_dat_o[4]) begin
                        tip_cnt = 2;
                        rxack_m = nack_en && (last_txr == 8'h46 || last_txr == 8'h48);
                    end
                    if (wb_dat_o[6]) stop_cnt = 2;
                end
            end else begin
                wb_dat_i = {rxack_m, stop_cnt != 0, 4'b0000, (tip_cnt != 0) || tip_stuck, 1'b0};
                if (tip_cnt != 0) tip_cnt--;
                if (stop_cnt != 0) stop_cnt--;
            end
        end else begin
            wb_ack_i = 1'b0;
        end
    end

    int          served[$];
    logic [15:0] exp_q[$];
    int          rd_pos = 0;

    // Advance one cycle; act as the upstream register file for clear pulses.
    task automatic step();
        @(negedge user_clk_i);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (clr_dac_o[i]) served.push_back(i);
        end
        for (int i = 0; i < 6; i++) begin
            if (clr_atten_o[i]) served.push_back(8 + i);
        end
        dac_pending_i   = dac_pending_i & ~clr_dac_o;
        atten_pending_i = atten_pending_i & ~clr_atten_o;
    endtask

    task automatic wait_quiet(input string tag, input int bound);
        int n = 0;
        do begin
            step();
            n++;
        end while ((dac_pending_i != 0 || atten_pending_i != 0 || busy_o) && n < bound);
        check(tag, {31'b0, busy_o || dac_pending_i != 0 || atten_pending_i != 0}, 32'd0);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(initialized_o && !busy_o) && n < 200);
        check(tag, {31'b0, initialized_o}, 32'd1);
    endtask

    task automatic ew(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({5'b0, a, d});
    endtask

    task automatic exp_init();
        ew(3'd2, 8'h00);
        ew(3'd0, 8'h31);
        ew(3'd1, 8'h00);
        ew(3'd2, 8'h80);
    endtask

    // bytes holds byte0 in its top octet.
    task automatic exp_frame(input int n, input logic [31:0] bytes);
        for (int i = 0; i < n; i++) begin
            ew(3'd3, bytes[31-8*i -: 8]);
            ew(3'd4, (i == 0) ? 8'h90 : 8'h10);
        end
        ew(3'd4, 8'h40);
    endtask

    task automatic check_writes(input string tag);
        check($sformatf("%s_count", tag), wr_log.size() - rd_pos, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (rd_pos + k < wr_log.size()) begin
                check($sformatf("%s[%0d]", tag, k), {16'b0, wr_log[rd_pos+k]}, {16'b0, exp_q[k]});
            end
        end
        rd_pos = wr_log.size();
        exp_q.delete();
    endtask

    task automatic check_served(input string tag, input int exp[$]);
        check($sformatf("%s_count", tag), served.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            if (k < served.size()) check($sformatf("%s[%0d]", tag, k), served[k], exp[k]);
        end
        served.delete();
    endtask

    initial begin
        int n;
        user_rst_i      = 1'b1;
        dac_pending_i   = 8'h00;
        atten_pending_i = 6'h00;
        dac_value_i     = '0;
        dac_value_i[11:0]  = 12'h123;
        dac_value_i[35:24] = 12'hABC;
        dac_value_i[71:60] = 12'h5A5;
        dac_eeprom_i    = 8'h01;
        atten_value_i   = {6'h15, 6'h14, 6'h13, 6'h12, 6'h11, 6'h10};
        pause_i         = 1'b0;
        init_req_i      = 1'b0;
        err_ack_i       = 1'b0;

        repeat (3) step();
        check("rst_initialized", {31'b0, initialized_o}, 0);
        check("rst_busy", {31'b0, busy_o}, 0);
        check("rst_wb_cyc", {31'b0, wb_cyc_o}, 0);
        check("rst_err", {23'b0, err_valid_o, err_code_o}, 0);
        check("rst_clr", {18'b0, clr_dac_o, clr_atten_o}, 0);
        user_rst_i = 1'b0;

        wait_init("init_done");
        exp_init();
        check_writes("init_wr");

        // Round robin from pointer 0: DAC0 then att0..att5.
        dac_pending_i   = 8'h01;
        atten_pending_i = 6'h3F;
        wait_quiet("rr_quiet", 3000);
        check_served("rr_order", '{0, 8, 9, 10, 11, 12, 13});
        exp_frame(4, 32'hC050_1230);
        exp_frame(2, 32'h4010_0000);
        exp_frame(2, 32'h4211_0000);
        exp_frame(2, 32'h4412_0000);
        exp_frame(2, 32'h4613_0000);
        exp_frame(2, 32'h4814_0000);
        exp_frame(2, 32'h4A15_0000);
        check_writes("rr_wr");

        // Single DAC2 frame, one clear pulse.
        dac_pending_i = 8'h04;
        wait_quiet("dac2_quiet", 500);
        check_served("dac2_clr", '{2});
        exp_frame(4, 32'hC042_ABC0);
        check_writes("dac2_wr");

        // NACK on att3 and att4 address: first error latched, second discarded.
        nack_en         = 1'b1;
        atten_pending_i = 6'h18;
        wait_quiet("nack_quiet", 500);
        nack_en = 1'b0;
        check_served("nack_clr", '{11, 12});
        ew(3'd3, 8'h46); ew(3'd4, 8'h90); ew(3'd4, 8'h40);
        ew(3'd3, 8'h48); ew(3'd4, 8'h90); ew(3'd4, 8'h40);
        check_writes("nack_wr");
        check("nack_err_valid", {31'b0, err_valid_o}, 1);
        check("nack_err_code", {24'b0, err_code_o}, 32'h63);
        err_ack_i = 1'b1;
        step();
        err_ack_i = 1'b0;
        check("ack_err_valid", {31'b0, err_valid_o}, 0);
        check("ack_err_code", {24'b0, err_code_o}, 0);

        // Pause asserted mid-frame: frame completes, then IDLE holds att0 pending.
        dac_pending_i = 8'h20;
        n = 0;
        do begin
            step();
            n++;
        end while (!(wb_cyc_o && wb_adr_o == 3'd3) && n < 100);
        check("pause_midframe", {31'b0, wb_cyc_o}, 1);
        pause_i         = 1'b1;
        atten_pending_i = 6'h01;
        n = 0;
        do begin
            step();
            n++;
        end while ((busy_o || dac_pending_i != 0) && n < 500);
        repeat (30) step();
        check("pause_busy", {31'b0, busy_o}, 0);
        check("pause_held", {26'b0, atten_pending_i}, 32'h01);
        check_served("pause_dac5", '{5});
        pause_i = 1'b0;
        wait_quiet("unpause_quiet", 500);
        check_served("unpause_att0", '{8});
        exp_frame(4, 32'hC045_5A50);
        exp_frame(2, 32'h4010_0000);
        check_writes("pause_wr");

        // Host-requested re-initialization.
        init_req_i = 1'b1;
        step();
        init_req_i = 1'b0;
        check("reinit_drop", {31'b0, initialized_o}, 0);
        wait_init("reinit_done");
        exp_init();
        check_writes("reinit_wr");

`ifdef GLITC_I2C_TIMEOUT_EN
        // TIP stuck high: timeout error, STO, re-init, channel dropped.
        tip_stuck       = 1'b1;
        atten_pending_i = 6'h01;
        n = 0;
        do begin
            step();
            n++;
        end while (!err_valid_o && n < 2000);
        tip_stuck = 1'b0;
        check("tmo_err_code", {24'b0, err_code_o}, 32'hA0);
        wait_quiet("tmo_quiet", 1000);
        check("tmo_reinit", {31'b0, initialized_o}, 1);
        check_served("tmo_clr", '{8});
        ew(3'd3, 8'h40); ew(3'd4, 8'h90); ew(3'd4, 8'h40);
        exp_init();
        check_writes("tmo_wr");
        err_ack_i = 1'b1;
        step();
        err_ack_i = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
